// File: rtl/aer_event_packetizer.sv
// Address-event packetizer: timestamps granted pixels into a first-word fall-through FIFO,
// paces the arbitration tree one pass per frame and closes each pass with an EOF word.
module aer_event_packetizer #(
    parameter int ROW_ADD    = 1,
    parameter int COL_ADD    = 1,
    parameter int POLARITY   = 2,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 2,
    localparam int W         = 2 + TS_W + ROW_ADD + COL_ADD,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic                active_i,
    input  logic [ROW_ADD-1:0]  x_add_i,
    input  logic [COL_ADD-1:0]  y_add_i,
    input  logic [POLARITY-1:0] polarity_i,
    input  logic                grp_release_i,
    output logic                arb_enable_o,
    output logic [W-1:0]        evt_data_o,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [LVL_W-1:0]    fifo_level_o,
    output logic [7:0]          overflow_cnt_o,
    output logic                frame_busy_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int AF_LVL = FIFO_DEPTH - AF_MARGIN;

    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_EOF} state_t;

    state_t             state_q, state_d;
    logic [TS_W-1:0]    ts_q;
    logic [W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [7:0]         ovf_q;

    logic               full, below_af, pop, eof_push, push_ok, drop;
    logic [W-1:0]       push_word;
    logic               unused_pol;

    assign unused_pol = ^polarity_i;

    // Stream handshake: a word transfers on every cycle where evt_valid_o and evt_ready_i
    // are both high; while evt_valid_o is high and evt_ready_i low, evt_data_o holds.
    always_comb begin
        full      = (level_q == LVL_W'(FIFO_DEPTH));
        below_af  = (level_q < LVL_W'(AF_LVL));
        pop       = (level_q != '0) && evt_ready_i;
        // Pixel grants win; the EOF word waits for a cycle without a grant.
        eof_push  = (state_q == ST_EOF) && !active_i && (!full || pop);
        push_ok   = (active_i && (!full || pop)) || eof_push;
        drop      = active_i && full && !pop;
        if (eof_push)
            push_word = {1'b1, ts_q, {(ROW_ADD + COL_ADD + 1){1'b0}}};
        else
            push_word = {1'b0, ts_q, x_add_i, y_add_i, polarity_i[0]};
    end

    always_comb begin
        state_d      = state_q;
        arb_enable_o = 1'b0;
        case (state_q)
            ST_IDLE: if (req_i && below_af) state_d = ST_ARB;
            ST_ARB: begin
                // Release ends the pass even while paused on almost-full.
                if (grp_release_i) state_d = ST_EOF;
                else               arb_enable_o = below_af;
            end
            ST_EOF:  if (eof_push) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + TS_W'(1);
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      level_q <= level_q + LVL_W'(1);
            else if (!push_ok && pop) level_q <= level_q - LVL_W'(1);
            if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    assign evt_valid_o    = (level_q != '0);
    assign evt_data_o     = mem[rd_ptr_q];
    assign fifo_level_o   = level_q;
    assign overflow_cnt_o = ovf_q;
    assign frame_busy_o   = (state_q != ST_IDLE);

endmodule
